// File: rtl/altr_hps_glitch_filter2.sv
// Dual-channel synchroniser and glitch filter feeding the HPS nor2 inputs.
// Ports: clk, rst_n (async low), filt_in1/2 raw levels, filt_len qualification
// length, filt_out1/2 filtered levels, filt_chg1/2 one-cycle change strobes.
module altr_hps_glitch_filter2 #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CNT_W  = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  filt_in1,
  input  logic                  filt_in2,
  input  logic [FILT_CNT_W-1:0] filt_len,
  output logic                  filt_out1,
  output logic                  filt_out2,
  output logic                  filt_chg1,
  output logic                  filt_chg2
);

  typedef enum logic {
    STABLE = 1'b0,
    QUAL   = 1'b1
  } state_t;

  localparam logic [FILT_CNT_W-1:0] ONE = FILT_CNT_W'(1);

  logic [1:0]            raw;
  logic [FILT_CNT_W-1:0] leff;

  assign raw  = {filt_in2, filt_in1};
  // A programmed length of zero behaves as a single-cycle filter.
  assign leff = (filt_len == '0) ? ONE : filt_len;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    state_t                 state_nx;
    logic [FILT_CNT_W-1:0]  cnt;
    logic [FILT_CNT_W-1:0]  cnt_nx;
    logic [FILT_CNT_W:0]    cnt_inc;
    logic                   tgl;
    logic                   o_q;
    logic                   chg_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= {SYNC_STAGES{RESET_VAL}};
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[c]};
      end
    end

    assign s = sync[SYNC_STAGES-1];

    // One extra bit so the compare cannot wrap at the maximum length.
    assign cnt_inc = {1'b0, cnt} + (FILT_CNT_W+1)'(1);

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tgl      = 1'b0;
      unique case (state)
        STABLE: begin
          if (s != o_q) begin
            if (leff == ONE) begin
              tgl = 1'b1;
            end else begin
              cnt_nx   = ONE;
              state_nx = QUAL;
            end
          end
        end
        QUAL: begin
          // A return to the current level wins over a completing count.
          if (s == o_q) begin
            cnt_nx   = '0;
            state_nx = STABLE;
          end else if (cnt_inc >= {1'b0, leff}) begin
            tgl      = 1'b1;
            cnt_nx   = '0;
            state_nx = STABLE;
          end else begin
            cnt_nx = cnt_inc[FILT_CNT_W-1:0];
          end
        end
        default: begin
          cnt_nx   = '0;
          state_nx = STABLE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= STABLE;
        cnt   <= '0;
        o_q   <= RESET_VAL;
        chg_q <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        o_q   <= o_q ^ tgl;
        chg_q <= tgl;
      end
    end
  end

  assign filt_out1 = g_ch[0].o_q;
  assign filt_out2 = g_ch[1].o_q;
  assign filt_chg1 = g_ch[0].chg_q;
  assign filt_chg2 = g_ch[1].chg_q;

endmodule

// File: tb/tb_altr_hps_glitch_filter2.sv
// Testbench for altr_hps_glitch_filter2: run-length reference model checked
// every cycle plus directed literal expectations.
module tb_altr_hps_glitch_filter2;

  localparam int SYNC = 2;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          filt_in1 = 1'b0;
  logic          filt_in2 = 1'b0;
  logic [CW-1:0] filt_len = '0;
  logic          filt_out1;
  logic          filt_out2;
  logic          filt_chg1;
  logic          filt_chg2;

  altr_hps_glitch_filter2 #(
    .SYNC_STAGES(SYNC),
    .FILT_CNT_W (CW),
    .RESET_VAL  (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .filt_in1 (filt_in1),
    .filt_in2 (filt_in2),
    .filt_len (filt_len),
    .filt_out1(filt_out1),
    .filt_out2(filt_out2),
    .filt_chg1(filt_chg1),
    .filt_chg2(filt_chg2)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int chg1_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output flips once its delayed input has disagreed with it
  // for Leff consecutive cycles; the delay line stands for the synchroniser.
  bit m_o   [2];
  bit m_chg [2];
  int run   [2];
  bit hist  [2][SYNC];

  always @(posedge clk) begin
    int  leff;
    bit  s;
    bit  inb [2];
    inb[0] = filt_in1;
    inb[1] = filt_in2;
    leff = (filt_len == 0) ? 1 : int'(filt_len);
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_o[c]   = 1'b0;
        m_chg[c] = 1'b0;
        run[c]   = 0;
        for (int k = 0; k < SYNC; k++) hist[c][k] = 1'b0;
      end else begin
        s        = hist[c][SYNC-1];
        m_chg[c] = 1'b0;
        if (s != m_o[c]) begin
          run[c]++;
          if (run[c] >= leff) begin
            m_o[c]   = ~m_o[c];
            m_chg[c] = 1'b1;
            run[c]   = 0;
          end
        end else begin
          run[c] = 0;
        end
        for (int k = SYNC-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = inb[c];
      end
    end
    #1;
    if (filt_chg1) chg1_seen++;
    chk("model_out1", int'(filt_out1), int'(m_o[0]));
    chk("model_out2", int'(filt_out2), int'(m_o[1]));
    chk("model_chg1", int'(filt_chg1), int'(m_chg[0]));
    chk("model_chg2", int'(filt_chg2), int'(m_chg[1]));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    // 1: reset default and first qualification
    filt_in1 = 1'b1;
    filt_in2 = 1'b1;
    filt_len = 4'd3;
    edges(3);
    chk("rst_out1", int'(filt_out1), 0);
    chk("rst_out2", int'(filt_out2), 0);
    chk("rst_chg1", int'(filt_chg1), 0);
    chk("rst_chg2", int'(filt_chg2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(4);
    chk("t1_pre_out1", int'(filt_out1), 0);
    edge1();
    chk("t1_rise_out1", int'(filt_out1), 1);
    chk("t1_rise_out2", int'(filt_out2), 1);
    chk("t1_chg1", int'(filt_chg1), 1);
    chk("t1_chg2", int'(filt_chg2), 1);
    edge1();
    chk("t1_chg1_end", int'(filt_chg1), 0);
    chk("t1_hold_out1", int'(filt_out1), 1);

    // 2: glitch rejection at length 4
    @(negedge clk);
    filt_in1 = 1'b0;
    filt_in2 = 1'b0;
    filt_len = 4'd4;
    idle(12);
    base = chg1_seen;
    filt_in1 = 1'b1;
    idle(3);
    filt_in1 = 1'b0;
    idle(10);
    chk("t2_glitch_out1", int'(filt_out1), 0);
    chk("t2_glitch_chg1", chg1_seen - base, 0);
    filt_in1 = 1'b1;
    edges(4);
    @(negedge clk);
    filt_in1 = 1'b0;
    edge1();
    chk("t2_e5_out1", int'(filt_out1), 0);
    edge1();
    chk("t2_e6_out1", int'(filt_out1), 1);
    chk("t2_e6_chg1", int'(filt_chg1), 1);
    edges(3);
    chk("t2_e9_out1", int'(filt_out1), 1);
    edge1();
    chk("t2_e10_out1", int'(filt_out1), 0);
    idle(4);

    // 3: zero length passes single-cycle pulses; length 1 alternating
    filt_len = 4'd0;
    filt_in1 = 1'b1;
    edge1();
    @(negedge clk);
    filt_in1 = 1'b0;
    edges(2);
    chk("t3_pulse_rise", int'(filt_out1), 1);
    chk("t3_pulse_chg", int'(filt_chg1), 1);
    edge1();
    chk("t3_pulse_fall", int'(filt_out1), 0);
    chk("t3_pulse_chg2", int'(filt_chg1), 1);
    idle(4);
    filt_len = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      filt_in1 = ~filt_in1;
      edge1();
      if (i >= 3) chk("t3_alt_chg1", int'(filt_chg1), 1);
    end
    idle(6);

    // 4: maximum length without wrap
    filt_len = 4'd15;
    filt_in2 = 1'b1;
    idle(14);
    filt_in2 = 1'b0;
    idle(20);
    chk("t4_short_out2", int'(filt_out2), 0);
    filt_in2 = 1'b1;
    edges(15);
    @(negedge clk);
    filt_in2 = 1'b0;
    edge1();
    chk("t4_e16_out2", int'(filt_out2), 0);
    edge1();
    chk("t4_e17_out2", int'(filt_out2), 1);
    chk("t4_e17_chg2", int'(filt_chg2), 1);
    idle(40);
    chk("t4_fall_out2", int'(filt_out2), 0);

    // 5: live length change mid-qualification
    filt_len = 4'd10;
    filt_in1 = 1'b1;
    edges(8);
    chk("t5_pre_out1", int'(filt_out1), 0);
    @(negedge clk);
    filt_len = 4'd5;
    edge1();
    chk("t5_out1", int'(filt_out1), 1);
    chk("t5_chg1", int'(filt_chg1), 1);
    @(negedge clk);
    filt_in1 = 1'b0;
    idle(15);

    // 6: reset mid-qualification, then channel independence
    filt_len = 4'd8;
    filt_in1 = 1'b1;
    filt_in2 = 1'b1;
    edges(6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out1", int'(filt_out1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(9);
    chk("t6_e9_out1", int'(filt_out1), 0);
    chk("t6_e9_out2", int'(filt_out2), 0);
    edge1();
    chk("t6_e10_out1", int'(filt_out1), 1);
    chk("t6_e10_out2", int'(filt_out2), 1);
    chk("t6_e10_chg1", int'(filt_chg1), 1);
    chk("t6_e10_chg2", int'(filt_chg2), 1);
    @(negedge clk);
    base = chg1_seen;
    filt_in2 = 1'b0;
    idle(20);
    chk("t6_ind_out1", int'(filt_out1), 1);
    chk("t6_ind_chg1", chg1_seen - base, 0);
    chk("t6_ind_out2", int'(filt_out2), 0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
